// File: rtl/summary_seq_emitter_pkg.sv
// Shared widths and the sequence entry format carried from the summary pipeline to the sequence encoder.
// Pure declarations: no latency, no flow control.
package summary_seq_emitter_pkg;

  localparam int JOB_LEN_LOG2    = 12;
  localparam int JOB_LEN         = 1 << JOB_LEN_LOG2;
  localparam int SEQ_LL_BITS     = 16;
  localparam int SEQ_ML_BITS     = 16;
  localparam int SEQ_OFFSET_BITS = 16;
  localparam int SEQ_IDX_BITS    = 16;

  typedef struct packed {
    logic [SEQ_LL_BITS-1:0]     ll;
    logic [SEQ_ML_BITS-1:0]     ml;
    logic [SEQ_OFFSET_BITS-1:0] offset;
    logic                       delim;
    logic                       last;
    logic [SEQ_IDX_BITS-1:0]    idx;
  } seq_entry_t;

  // A summary carrying no literals, no match and no end-of-job produces no sequence.
  function automatic logic is_null_summary(input logic [SEQ_LL_BITS-1:0] ll,
                                           input logic [SEQ_ML_BITS-1:0] ml,
                                           input logic                   eoj);
    return (ll == '0) && (ml == '0) && !eoj;
  endfunction

endpackage

// File: rtl/summary_seq_emitter_seq_fifo.sv
// Synchronous first-word-fall-through FIFO; read data is the head entry, valid whenever not empty.
// Zero-latency read; caller gates push/pop, overfull pushes and empty pops are ignored.
module summary_seq_emitter_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  // When full, a same-cycle pop frees the slot the write pointer already aims at.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/summary_seq_emitter.sv
// Turns each summary_done into registered head feedback plus a queued sequence for the encoder.
// Head feedback 1 cycle after the strobe; FIFO is FWFT, upstream cannot stall so o_stall leads by INFLIGHT.
module summary_seq_emitter
  import summary_seq_emitter_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int INFLIGHT   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_summary_done,
  input  logic [JOB_LEN_LOG2-1:0]    i_seq_head_ptr,
  input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
  input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
  input  logic                       i_summary_delim,
  input  logic                       i_summary_eoj,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
  input  logic                       i_move_to_next_job,
  input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
  output logic                       o_head_valid,
  output logic [JOB_LEN_LOG2-1:0]    o_next_head_ptr,
  output logic                       o_job_advance,
  output logic                       o_stall,
  output logic                       o_seq_valid,
  input  logic                       i_seq_ready,
  output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
  output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
  output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
  output logic                       o_seq_last,
  output logic                       o_seq_delim,
  output logic [SEQ_IDX_BITS-1:0]    o_seq_idx,
  output logic                       o_overflow,
  output logic                       o_bad_overlap
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(seq_entry_t);
  localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - INFLIGHT);

  seq_entry_t        push_ent;
  seq_entry_t        head_ent;
  logic [EW-1:0]     fifo_rd_dat;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, count_d;
  logic              push_req, push_fire, pop_fire;

  logic [SEQ_IDX_BITS-1:0] idx_q, idx_d;
  logic                    head_vld_q, head_vld_d;
  logic [JOB_LEN_LOG2-1:0] head_ptr_q, head_ptr_d;
  logic                    job_adv_q, job_adv_d;
  logic                    stall_q, stall_d;
  logic                    overflow_q, overflow_d;
  logic                    bad_overlap_q, bad_overlap_d;

  // Job switching is signalled authoritatively by eoj; the scheduler's own flag is not needed here.
  logic unused_move_to_next_job;
  assign unused_move_to_next_job = i_move_to_next_job;

  always_comb begin
    push_ent        = '0;
    push_ent.ll     = i_summary_ll;
    push_ent.ml     = i_summary_ml;
    push_ent.offset = i_summary_offset;
    push_ent.delim  = i_summary_delim;
    push_ent.last   = i_summary_eoj;
    push_ent.idx    = idx_q;
  end

  assign push_req  = i_summary_done && !is_null_summary(i_summary_ll, i_summary_ml, i_summary_eoj);
  assign pop_fire  = i_seq_ready && !fifo_empty;
  assign push_fire = push_req && (!fifo_full || pop_fire);

  always_comb begin
    count_d = fifo_count;
    if (push_fire && !pop_fire)      count_d = fifo_count + 1'b1;
    else if (pop_fire && !push_fire) count_d = fifo_count - 1'b1;
  end

  summary_seq_emitter_seq_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_seq_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_fire),
    .push_dat_i (push_ent),
    .pop_i      (pop_fire),
    .pop_dat_o  (fifo_rd_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    idx_d         = idx_q;
    head_vld_d    = i_summary_done;
    head_ptr_d    = '0;
    job_adv_d     = 1'b0;
    bad_overlap_d = bad_overlap_q;
    overflow_d    = overflow_q || (push_req && !push_fire);
    stall_d       = (count_d >= STALL_AT);

    // Only entries that actually land in the FIFO consume an index.
    if (push_fire) begin
      if (i_summary_eoj)          idx_d = '0;
      else if (idx_q != '1)       idx_d = idx_q + 1'b1;
    end

    if (i_summary_done) begin
      if (i_summary_eoj) begin
        job_adv_d = 1'b1;
        // JOB_LEN is a power of two, so any bit above the pointer width means overlap >= JOB_LEN.
        if (|i_summary_overlap_len[SEQ_ML_BITS-1:JOB_LEN_LOG2]) bad_overlap_d = 1'b1;
        else head_ptr_d = i_summary_overlap_len[JOB_LEN_LOG2-1:0];
      end else begin
        head_ptr_d = i_seq_head_ptr + i_move_forward;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      head_vld_q    <= 1'b0;
      head_ptr_q    <= '0;
      job_adv_q     <= 1'b0;
      stall_q       <= 1'b0;
      overflow_q    <= 1'b0;
      bad_overlap_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      head_vld_q    <= head_vld_d;
      head_ptr_q    <= head_ptr_d;
      job_adv_q     <= job_adv_d;
      stall_q       <= stall_d;
      overflow_q    <= overflow_d;
      bad_overlap_q <= bad_overlap_d;
    end
  end

  // FIFO storage is not reset, so present zeros whenever there is no valid head.
  assign head_ent = fifo_empty ? '0 : seq_entry_t'(fifo_rd_dat);

  assign o_head_valid    = head_vld_q;
  assign o_next_head_ptr = head_ptr_q;
  assign o_job_advance   = job_adv_q;
  assign o_stall         = stall_q;
  assign o_overflow      = overflow_q;
  assign o_bad_overlap   = bad_overlap_q;
  assign o_seq_valid     = !fifo_empty;
  assign o_seq_ll        = head_ent.ll;
  assign o_seq_ml        = head_ent.ml;
  assign o_seq_offset    = head_ent.offset;
  assign o_seq_delim     = head_ent.delim;
  assign o_seq_last      = head_ent.last;
  assign o_seq_idx       = head_ent.idx;

endmodule
